viterbi_frame_ctrl: RTL

Frame-level sequencer for the K=5, rate-1/2 Viterbi decoder datapath. The decoder has no enable and advances every clock, so this block guarantees gap-free symbol delivery to it:
- clears the decoder before each frame;
- streams FRAME_LEN symbol pairs from an upstream valid/ready source, then FLUSH_LEN zero tail pairs;
- drains the decoder's fixed latency and re-times decoded bits into a framed output stream with last and done markers.

---
 rtl/viterbi_pkg.sv | 21 ++
 rtl/viterbi_frame_ctrl_if.sv | 23 ++
 rtl/viterbi_out_align.sv | 55 +++++
 rtl/viterbi_frame_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=5 rate-1/2 Viterbi frame controller:
// FSM state encoding, code geometry and generator polynomials.
package viterbi_pkg;

    localparam int K           = 5;
    localparam int CODE_W      = 2;
    localparam int DEC_LAT_DEF = 18;

    localparam logic [K-1:0] G0_POLY = 5'b11101;
    localparam logic [K-1:0] G1_POLY = 5'b10011;

    typedef enum logic [2:0] {
        IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE, ABORT
    } state_e;

    // Encoder output {g1,g0} for a shift register holding the newest bit in [K-1].
    function automatic logic [CODE_W-1:0] enc_pair(input logic [K-1:0] sr);
        return {^(sr & G1_POLY), ^(sr & G0_POLY)};
    endfunction

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Symbol input stream and decoded-bit output stream of the frame controller.
// master = the controller, slave = the surrounding source/sink.
interface viterbi_frame_ctrl_if;
    import viterbi_pkg::*;

    logic              sym_valid;
    logic [CODE_W-1:0] sym_data;
    logic              sym_ready;
    logic              out_valid;
    logic              out_bit;
    logic              out_last;

    modport master (
        input  sym_valid, sym_data,
        output sym_ready, out_valid, out_bit, out_last
    );

    modport slave (
        output sym_valid, sym_data,
        input  sym_ready, out_valid, out_bit, out_last
    );

endinterface

// File: rtl/viterbi_out_align.sv
// Counts decoder latency from the first symbol pair, then re-times exactly
// FRAME_LEN decoded bits into the framed output; tail bits are never emitted.
module viterbi_out_align #(
    parameter int FRAME_LEN = 32,
    parameter int DEC_LAT   = 18,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             squash,
    input  logic             dec_bit,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    output logic [CNT_W-1:0] out_cnt
);

    logic             run;
    logic [CNT_W-1:0] lat_cnt;
    logic             cap;

    // run rises with the first pair on dec_code, so lat_cnt==DEC_LAT marks the
    // cycle its decoded bit sits on dec_bit.
    assign cap = run && (lat_cnt == CNT_W'(DEC_LAT)) && (out_cnt != CNT_W'(FRAME_LEN));

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            run       <= 1'b0;
            lat_cnt   <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
        end else if (squash) begin
            run       <= 1'b0;
            lat_cnt   <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (start)
                run <= 1'b1;
            if (run && lat_cnt != CNT_W'(DEC_LAT))
                lat_cnt <= lat_cnt + CNT_W'(1);
            if (cap)
                out_cnt <= out_cnt + CNT_W'(1);
            out_valid <= cap;
            out_bit   <= cap & dec_bit;
            out_last  <= cap && (out_cnt == CNT_W'(FRAME_LEN - 1));
        end
    end

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for a free-running Viterbi decoder: clear, gap-free feed,
// zero flush, latency drain. Optional counters under VITERBI_CTRL_STATS_EN.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 32,
    parameter int FLUSH_LEN = 4,
    parameter int DEC_LAT   = DEC_LAT_DEF,
    parameter int CLR_CYC   = 2,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 frame_start,
    output logic                 frame_busy,
    viterbi_frame_ctrl_if.master strm,
    output logic                 dec_res,
    output logic [CODE_W-1:0]    dec_code,
    input  logic                 dec_bit,
    output logic                 frame_done,
    output logic                 frame_err
`ifdef VITERBI_CTRL_STATS_EN
    ,
    output logic [15:0]          stat_frames,
    output logic [15:0]          stat_aborts
`endif
);

    state_e           state, state_nx;
    logic [CNT_W-1:0] clr_cnt, in_cnt, fl_cnt, out_cnt;
    logic             accept, clear_go, abort_go, start_go;

    assign accept   = (state == FEED) && strm.sym_valid;
    assign clear_go = (state == IDLE) && frame_start;
    assign abort_go = (state == FEED) && !strm.sym_valid;
    assign start_go = accept && (in_cnt == '0);

    always_ff @(posedge clk or negedge res) begin
        if (!res) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (frame_start) state_nx = CLEAR;
            CLEAR: if (clr_cnt == CNT_W'(CLR_CYC - 1)) state_nx = FEED;
            FEED: begin
                // any bubble would desynchronise the free-running decoder
                if (!strm.sym_valid)                     state_nx = ABORT;
                else if (in_cnt == CNT_W'(FRAME_LEN - 1)) state_nx = FLUSH;
            end
            FLUSH: if (fl_cnt == CNT_W'(FLUSH_LEN - 1)) state_nx = DRAIN;
            DRAIN: if (out_cnt == CNT_W'(FRAME_LEN)) state_nx = DONE;
            DONE:  state_nx = IDLE;
            ABORT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        frame_busy     = (state != IDLE);
        strm.sym_ready = (state == FEED);
        frame_done     = (state == DONE);
        frame_err      = (state == ABORT);
    end

    // dec_res follows the next state so its low time matches CLEAR/ABORT exactly.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            dec_res  <= 1'b0;
            dec_code <= '0;
            clr_cnt  <= '0;
            in_cnt   <= '0;
            fl_cnt   <= '0;
        end else begin
            dec_res  <= !((state_nx == CLEAR) || (state_nx == ABORT));
            dec_code <= accept ? strm.sym_data : '0;
            if (clear_go) begin
                clr_cnt <= '0;
                in_cnt  <= '0;
                fl_cnt  <= '0;
            end else begin
                if (state == CLEAR) clr_cnt <= clr_cnt + CNT_W'(1);
                if (accept)         in_cnt  <= in_cnt + CNT_W'(1);
                if (state == FLUSH) fl_cnt  <= fl_cnt + CNT_W'(1);
            end
        end
    end

    viterbi_out_align #(
        .FRAME_LEN (FRAME_LEN),
        .DEC_LAT   (DEC_LAT),
        .CNT_W     (CNT_W)
    ) u_align (
        .clk       (clk),
        .res       (res),
        .start     (start_go),
        .squash    (clear_go | abort_go),
        .dec_bit   (dec_bit),
        .out_valid (strm.out_valid),
        .out_bit   (strm.out_bit),
        .out_last  (strm.out_last),
        .out_cnt   (out_cnt)
    );

`ifdef VITERBI_CTRL_STATS_EN
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            stat_frames <= '0;
            stat_aborts <= '0;
        end else begin
            if (frame_done && stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
            if (frame_err  && stat_aborts != 16'hFFFF) stat_aborts <= stat_aborts + 16'd1;
        end
    end
`endif

endmodule
